// File: rtl/wishbone_master.sv
// wishbone_master: valid/ready request/response to single Wishbone classic cycles,
// with a bus timeout so a silent slave cannot hang the requester.
module wishbone_master #(
   parameter int adr_width      = 8,
   parameter int dat_width      = 8,
   parameter int sel_width      = 1,
   parameter int timeout_cycles = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [adr_width-1:0] req_adr,
   input  logic [dat_width-1:0] req_dat,
   input  logic [sel_width-1:0] req_sel,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [dat_width-1:0] rsp_dat,
   output logic                 rsp_err,
   output logic [adr_width-1:0] adr,
   output logic [dat_width-1:0] datwr,
   input  logic [dat_width-1:0] datrd,
   output logic [sel_width-1:0] sel,
   output logic                 we,
   output logic                 stb,
   output logic                 cyc,
   input  logic                 ack
);
   localparam int cw = $clog2(timeout_cycles) + 1;
   localparam logic [cw-1:0] cnt_max = cw'(timeout_cycles - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t               state_q, state_d;
   logic [cw-1:0]        cnt_q, cnt_d;
   logic                 cyc_q, cyc_d;
   logic                 we_q, we_d;
   logic [adr_width-1:0] adr_q, adr_d;
   logic [dat_width-1:0] datwr_q, datwr_d;
   logic [sel_width-1:0] sel_q, sel_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [dat_width-1:0] rsp_dat_q, rsp_dat_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      datwr_d     = datwr_q;
      sel_d       = sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            adr_d   = req_adr;
            datwr_d = req_dat;
            sel_d   = req_sel;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
         end
         // ack has priority over a timeout landing on the same edge
         BUS: if (ack || cnt_q == cnt_max) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !ack;
            rsp_dat_d   = (ack && !we_q) ? datrd : '0;
            state_d     = RESP;
         end else begin
            cnt_d = cnt_q + cw'(1);
         end
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         datwr_q     <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         datwr_q     <= datwr_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign cyc       = cyc_q;
   assign stb       = cyc_q;
   assign we        = we_q;
   assign adr       = adr_q;
   assign datwr     = datwr_q;
   assign sel       = sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_dat   = rsp_dat_q;
endmodule
